cp0_exception_unit: RTL and testbench

//  Coprocessor-0 register file and exception sequencer for the single-issue MIPS core.

---
 rtl/cp0_exception_unit_pkg.sv | 26 ++
 rtl/cp0_exception_unit_irq_pending.sv | 69 ++++++
 rtl/cp0_exception_unit.sv | 145 ++++++++++++++
 tb/tb_cp0_exception_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exception_unit_pkg.sv
// Shared definitions for the CP0 exception unit: CP0 register numbers, exception codes,
// STATUS/CAUSE field positions and the sequencer state encoding.
package cp0_exception_unit_pkg;

    // CP0 register numbers (rd field of mfc0/mtc0)
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // CAUSE.ExcCode values
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    // Field positions
    localparam int unsigned STATUS_IE_BIT  = 0;
    localparam int unsigned STATUS_IM_LSB  = 8;
    localparam int unsigned CAUSE_IP_LSB   = 8;
    localparam int unsigned CAUSE_EXC_LSB  = 2;
    localparam int unsigned EXC_CODE_W     = 5;

    typedef enum logic {
        StRun     = 1'b0,
        StHandler = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_exception_unit_irq_pending.sv
// Interrupt pending tracker: rising-edge detection on the external lines, the CAUSE.IP latch,
// masking with STATUS.IM and a lowest-index priority pick.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   irq_i          external interrupt levels
//   im_i           interrupt mask (STATUS.IM)
//   svc_i          an interrupt is being taken this cycle: clear the selected IP bit
//   wr_en_i        software write of CAUSE.IP this cycle
//   wr_ip_i        value written to CAUSE.IP
//   ip_o           current CAUSE.IP
//   req_o          at least one pending and unmasked interrupt
module cp0_irq_pending #(
    parameter int unsigned NIRQ = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NIRQ-1:0] irq_i,
    input  logic [NIRQ-1:0] im_i,
    input  logic            svc_i,
    input  logic            wr_en_i,
    input  logic [NIRQ-1:0] wr_ip_i,
    output logic [NIRQ-1:0] ip_o,
    output logic            req_o
);

    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] ip_q, ip_d;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] sel;
    logic            found;

    assign rise  = irq_i & ~irq_q;
    assign pend  = ip_q & im_i;
    assign req_o = |pend;
    assign ip_o  = ip_q;

    // Lowest index wins among pending, unmasked lines
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (pend[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    // A new edge is OR-ed in last so it survives a same-cycle clear
    always_comb begin
        ip_d = wr_en_i ? wr_ip_i : ip_q;
        if (svc_i) begin
            ip_d = ip_d & ~sel;
        end
        ip_d = ip_d | rise;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= '0;
            ip_q  <= '0;
        end else begin
            irq_q <= irq_i;
            ip_q  <= ip_d;
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file (STATUS, CAUSE, EPC) and exception sequencer for the single-issue core.
// Decides in the commit cycle whether the instruction is pre-empted by an interrupt or syscall,
// or is an ERET, and tracks handler state so interrupts do not nest.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   irq             external interrupt levels (already synchronised)
//   instr_valid     committing instruction is real
//   pc_cur          PC of the committing instruction
//   sys/exce_ret/mfc0/mtc0  decoder strobes
//   cp0_addr, wdata CP0 register number and mtc0 data
//   rdata           mfc0 read data (combinational, pre-edge values)
//   take_exc        redirect to EXC_VECTOR and flush (combinational)
//   take_eret       redirect to epc_out (combinational)
//   epc_out         current EPC
//   in_handler      sequencer is in the handler state
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter int unsigned NIRQ       = 4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic            instr_valid,
    input  logic [31:0]     pc_cur,
    input  logic            sys,
    input  logic            exce_ret,
    input  logic            mfc0,
    input  logic            mtc0,
    input  logic [4:0]      cp0_addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            take_exc,
    output logic            take_eret,
    output logic [31:0]     epc_out,
    output logic            in_handler
);

    if (NIRQ < 1 || NIRQ > 8) begin : g_bad_nirq
        $error("cp0_exception_unit: NIRQ must be within 1..8");
    end
    if (EXC_VECTOR[1:0] != 2'b00) begin : g_bad_vector
        $error("cp0_exception_unit: EXC_VECTOR must be word aligned");
    end

    cp0_state_e            state_q, state_d;
    logic                  ie_q, ie_d;
    logic [NIRQ-1:0]       im_q, im_d;
    logic [EXC_CODE_W-1:0] exc_code_q, exc_code_d;
    logic [31:0]           epc_q, epc_d;

    logic [NIRQ-1:0] ip;
    logic            irq_pend;
    logic            int_req;
    logic            exc_req;
    logic            mtc0_en;
    logic            ip_wr;

    assign int_req   = instr_valid & ie_q & irq_pend & (state_q == StRun);
    assign exc_req   = int_req | (instr_valid & sys);
    assign take_exc  = exc_req;
    assign take_eret = instr_valid & exce_ret & ~exc_req;
    // ERET and exceptions both outrank a register write in the same cycle
    assign mtc0_en   = instr_valid & mtc0 & ~exc_req & ~take_eret;
    assign ip_wr     = mtc0_en & (cp0_addr == CP0_CAUSE);

    assign epc_out    = epc_q;
    assign in_handler = (state_q == StHandler);

    cp0_irq_pending #(
        .NIRQ(NIRQ)
    ) u_irq_pending (
        .clk_i   (clk),
        .rst_i   (rst),
        .irq_i   (irq),
        .im_i    (im_q),
        .svc_i   (int_req),
        .wr_en_i (ip_wr),
        .wr_ip_i (wdata[CAUSE_IP_LSB +: NIRQ]),
        .ip_o    (ip),
        .req_o   (irq_pend)
    );

    always_comb begin
        state_d    = state_q;
        ie_d       = ie_q;
        im_d       = im_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (exc_req) begin
            epc_d      = pc_cur;
            ie_d       = 1'b0;
            state_d    = StHandler;
            exc_code_d = int_req ? EXC_INT : EXC_SYS;
        end else if (take_eret) begin
            ie_d    = 1'b1;
            state_d = StRun;
        end else if (mtc0_en) begin
            case (cp0_addr)
                CP0_STATUS: begin
                    ie_d = wdata[STATUS_IE_BIT];
                    im_d = wdata[STATUS_IM_LSB +: NIRQ];
                end
                CP0_EPC: epc_d = wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (cp0_addr)
                CP0_STATUS: begin
                    rdata[STATUS_IE_BIT]         = ie_q;
                    rdata[STATUS_IM_LSB +: NIRQ] = im_q;
                end
                CP0_CAUSE: begin
                    rdata[CAUSE_IP_LSB +: NIRQ]        = ip;
                    rdata[CAUSE_EXC_LSB +: EXC_CODE_W] = exc_code_q;
                end
                CP0_EPC: rdata = epc_q;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            ie_q       <= 1'b0;
            im_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            im_q       <= im_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
module tb_cp0_exception_unit;

    localparam int unsigned NIRQ = 4;
    localparam logic [31:0] MASK = 32'h0000_000F;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq;
    logic            instr_valid;
    logic [31:0]     pc_cur;
    logic            sys, exce_ret, mfc0, mtc0;
    logic [4:0]      cp0_addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            take_exc, take_eret;
    logic [31:0]     epc_out;
    logic            in_handler;

    int checks   = 0;
    int failures = 0;

    // Reference model state (plain integers)
    bit          m_ie;
    logic [31:0] m_im, m_ip, m_code, m_epc, m_irq_prev;
    bit          m_hand;

    // Values seen in the most recent cycle, for directed checks
    logic [31:0] rd_seen;
    logic        te_seen, tr_seen;

    always #5 clk = ~clk;

    cp0_exception_unit #(
        .NIRQ      (NIRQ),
        .EXC_VECTOR(32'h0000_0080)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .instr_valid(instr_valid),
        .pc_cur     (pc_cur),
        .sys        (sys),
        .exce_ret   (exce_ret),
        .mfc0       (mfc0),
        .mtc0       (mtc0),
        .cp0_addr   (cp0_addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .take_exc   (take_exc),
        .take_eret  (take_eret),
        .epc_out    (epc_out),
        .in_handler (in_handler)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_im = 0; m_ip = 0; m_code = 0; m_epc = 0; m_irq_prev = 0; m_hand = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return (m_im << 8) | {31'b0, m_ie};
            5'd13:   return (m_ip << 8) | (m_code << 2);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        instr_valid = 0; sys = 0; exce_ret = 0; mfc0 = 0; mtc0 = 0;
        cp0_addr = 0; wdata = 0; pc_cur = 0;
    endtask

    // One clock: compare combinational outputs at the negedge, then advance the model
    task automatic cycle();
        logic [31:0] pend, exp_rd, rise;
        bit int_req, exc, eret, wr, hit;
        @(negedge clk);
        pend    = m_ip & m_im;
        int_req = instr_valid && m_ie && (pend != 0) && !m_hand;
        exc     = int_req || (instr_valid && sys);
        eret    = instr_valid && exce_ret && !exc;
        wr      = instr_valid && mtc0 && !exc && !eret;
        exp_rd  = mfc0 ? model_read(cp0_addr) : 32'h0;
        rd_seen = rdata; te_seen = take_exc; tr_seen = take_eret;
        check("take_exc", {31'b0, take_exc}, {31'b0, exc});
        check("take_eret", {31'b0, take_eret}, {31'b0, eret});
        check("epc_out", epc_out, m_epc);
        check("in_handler", {31'b0, in_handler}, {31'b0, m_hand});
        if (mfc0) check("rdata", rdata, exp_rd);
        @(posedge clk);
        rise = {28'b0, irq} & ~m_irq_prev;
        m_irq_prev = {28'b0, irq};
        if (exc) begin
            m_epc = pc_cur; m_ie = 0; m_hand = 1;
            m_code = int_req ? 32'd0 : 32'd8;
            if (int_req) begin
                hit = 0;
                for (int i = 0; i < NIRQ; i++)
                    if (!hit && pend[i]) begin m_ip[i] = 1'b0; hit = 1; end
            end
        end else if (eret) begin
            m_ie = 1; m_hand = 0;
        end else if (wr) begin
            if (cp0_addr == 5'd12) begin m_ie = wdata[0]; m_im = (wdata >> 8) & MASK; end
            if (cp0_addr == 5'd13) m_ip = (wdata >> 8) & MASK;
            if (cp0_addr == 5'd14) m_epc = wdata;
        end
        m_ip = m_ip | rise;
        #1;
    endtask

    task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); instr_valid = 1; mtc0 = 1; cp0_addr = a; wdata = d; cycle(); idle();
    endtask

    task automatic do_read(input logic [4:0] a);
        idle(); mfc0 = 1; cp0_addr = a; cycle(); idle();
    endtask

    task automatic do_instr(input logic [31:0] pc, input bit s, input bit er);
        idle(); instr_valid = 1; pc_cur = pc; sys = s; exce_ret = er; cycle(); idle();
    endtask

    initial begin
        rst = 1; irq = 0; idle(); model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // 1: reset values, irq toggling with IE=0
        do_read(5'd12); check("rst_status", rd_seen, 32'h0);
        do_read(5'd13); check("rst_cause", rd_seen, 32'h0);
        do_read(5'd14); check("rst_epc", rd_seen, 32'h0);
        for (int i = 0; i < 6; i++) begin
            irq = 4'(i); do_instr(32'h100 + 32'(4 * i), 0, 0);
            check("ie0_no_exc", {31'b0, te_seen}, 32'h0);
        end
        irq = 0; do_mtc0(5'd13, 32'h0); // ack whatever got latched

        // 2: enable irq0/1, pulse irq1, commit at 0x400
        do_mtc0(5'd12, 32'h0000_0301);
        irq = 4'b0010; cycle(); irq = 0; cycle();
        do_instr(32'h400, 0, 0);
        check("t2_take", {31'b0, te_seen}, 32'h1);
        do_read(5'd14); check("t2_epc", rd_seen, 32'h400);
        do_read(5'd13); check("t2_cause", rd_seen, 32'h0);
        do_read(5'd12); check("t2_status", rd_seen, 32'h300);

        // 3: ERET
        do_instr(32'h480, 0, 1);
        check("t3_eret", {31'b0, tr_seen}, 32'h1);
        check("t3_epc", epc_out, 32'h400);
        do_read(5'd12); check("t3_status", rd_seen, 32'h301);
        check("t3_hand", {31'b0, in_handler}, 32'h0);

        // 4: syscall with IE=0, then syscall racing a pending irq0
        do_mtc0(5'd12, 32'h0000_0300);
        do_instr(32'h500, 1, 0);
        check("t4_sys_take", {31'b0, te_seen}, 32'h1);
        do_read(5'd13); check("t4_code8", rd_seen, 32'h20);
        check("t4_epc", epc_out, 32'h500);
        do_instr(32'h504, 0, 1);
        irq = 4'b0001; cycle(); irq = 0;
        do_instr(32'h600, 1, 0);
        do_read(5'd13); check("t4_code0", rd_seen, 32'h0);
        check("t4_epc2", epc_out, 32'h600);
        do_instr(32'h604, 0, 1);

        // 5: irq2 and irq3 together, lowest index first
        do_mtc0(5'd12, 32'h0000_0F01);
        irq = 4'b1100; cycle(); irq = 0;
        do_instr(32'h700, 0, 0);
        do_read(5'd13); check("t5_ip3_left", rd_seen, 32'h800);
        do_instr(32'h704, 0, 1);
        do_instr(32'h710, 0, 0);
        check("t5_second", {31'b0, te_seen}, 32'h1);
        do_read(5'd13); check("t5_ip_empty", rd_seen, 32'h0);
        do_instr(32'h714, 0, 1);

        // 6: level-held line sets IP once; async reset in handler
        do_mtc0(5'd12, 32'h0000_0100);
        irq = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i == 3) do_mtc0(5'd13, 32'h0);
        end
        do_read(5'd13); check("t6_held_once", rd_seen, 32'h0);
        irq = 0;
        do_instr(32'h800, 1, 0);
        check("t6_in_hand", {31'b0, in_handler}, 32'h1);
        rst = 1; #1;
        check("t6_rst_hand", {31'b0, in_handler}, 32'h0);
        check("t6_rst_epc", epc_out, 32'h0);
        mfc0 = 1; cp0_addr = 5'd13; #1;
        check("t6_rst_cause", rdata, 32'h0);
        idle(); rst = 0; model_reset();
        cycle();

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            instr_valid = ($urandom_range(0, 3) != 0);
            sys         = ($urandom_range(0, 15) == 0);
            exce_ret    = ($urandom_range(0, 5) == 0);
            mfc0        = ($urandom_range(0, 1) == 0);
            mtc0        = ($urandom_range(0, 3) == 0);
            cp0_addr    = 5'(11 + $urandom_range(0, 4));
            wdata       = $urandom;
            pc_cur      = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 2) == 0) irq = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
